// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the MEM-stage memory access block.
package mem_access_pkg;

  localparam int          MA_DATA_W    = 16;
  localparam logic [15:0] MA_MMIO_BASE = 16'hBF00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access.sv
// MEM-stage access FSM: IDLE -> ACCESS (until ack) -> DONE, stalling the front of the pipe.
// Define MEM_ACCESS_MMIO_EN to route MMIO_BASE/MMIO_BASE+1 to the io* handshake.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int                DATA_W    = MA_DATA_W,
  parameter logic [DATA_W-1:0] MMIO_BASE = DATA_W'(MA_MMIO_BASE)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              memReadIn,
  input  logic              memWriteIn,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic [DATA_W-1:0] storeDataIn,
  input  logic [1:0]        writeSpecRegIn,
  input  logic              memtoRegIn,
  input  logic              regWriteIn,
  input  logic [2:0]        registerToWriteIdIn,
  output logic [1:0]        writeSpecRegOut,
  output logic              memtoRegOut,
  output logic              regWriteOut,
  output logic [2:0]        registerToWriteIdOut,
  output logic [DATA_W-1:0] dataOut,
  output logic [DATA_W-1:0] ALUResultOut,
  output logic              stallOut,
  output logic              ramReq,
  output logic              ramWe,
  output logic [DATA_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata,
  input  logic              ramAck
`ifdef MEM_ACCESS_MMIO_EN
  ,
  output logic              ioReq,
  output logic              ioWe,
  output logic              ioSel,
  output logic [DATA_W-1:0] ioWdata,
  input  logic [DATA_W-1:0] ioRdata,
  input  logic              ioAck
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              io_q, io_d;

  logic              mem_op;
  logic              mmio_hit;
  logic              acc_ack;
  logic [DATA_W-1:0] acc_rdata;

  assign mem_op = memReadIn | memWriteIn;

`ifdef MEM_ACCESS_MMIO_EN
  assign mmio_hit  = (ALUResultIn == MMIO_BASE) || (ALUResultIn == MMIO_BASE + DATA_W'(1));
  assign acc_ack   = io_q ? ioAck   : ramAck;
  assign acc_rdata = io_q ? ioRdata : ramRdata;
  assign ioSel     = addr_q[0];
  assign ioWdata   = wdata_q;
`else
  logic unused_mmio;
  assign unused_mmio = ^MMIO_BASE;
  assign mmio_hit    = 1'b0;
  assign acc_ack     = ramAck;
  assign acc_rdata   = ramRdata;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      we_q    <= we_d;
      io_q    <= io_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    we_d     = we_q;
    io_d     = io_q;
    stallOut = 1'b0;
    ramReq   = 1'b0;
    ramWe    = 1'b0;
`ifdef MEM_ACCESS_MMIO_EN
    ioReq    = 1'b0;
    ioWe     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          stallOut = 1'b1;
          state_d  = ST_ACCESS;
          addr_d   = ALUResultIn;
          wdata_d  = storeDataIn;
          we_d     = memWriteIn;  // read+write together is a write
          io_d     = mmio_hit;
        end
      end
      ST_ACCESS: begin
        stallOut = 1'b1;
`ifdef MEM_ACCESS_MMIO_EN
        if (io_q) begin
          ioReq = 1'b1;
          ioWe  = we_q;
        end else begin
          ramReq = 1'b1;
          ramWe  = we_q;
        end
`else
        ramReq = 1'b1;
        ramWe  = we_q;
`endif
        if (acc_ack) begin
          if (!we_q) data_d = acc_rdata;
          state_d = ST_DONE;
        end
      end
      // EX_MEM still holds the finished op here; returning to IDLE keeps it from re-issuing.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ramAddr              = addr_q;
  assign ramWdata             = wdata_q;
  assign dataOut              = (state_q == ST_DONE) ? data_q : '0;
  assign ALUResultOut         = ALUResultIn;
  assign registerToWriteIdOut = registerToWriteIdIn;
  assign regWriteOut          = stallOut ? 1'b0 : regWriteIn;
  assign memtoRegOut          = stallOut ? 1'b0 : memtoRegIn;
  assign writeSpecRegOut      = stallOut ? 2'b00 : writeSpecRegIn;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized ops against a cycle-count model.
module tb_mem_access;

  logic        CLK, RST;
  logic        memReadIn, memWriteIn;
  logic [15:0] ALUResultIn, storeDataIn;
  logic [1:0]  writeSpecRegIn;
  logic        memtoRegIn, regWriteIn;
  logic [2:0]  registerToWriteIdIn;
  logic [1:0]  writeSpecRegOut;
  logic        memtoRegOut, regWriteOut;
  logic [2:0]  registerToWriteIdOut;
  logic [15:0] dataOut, ALUResultOut;
  logic        stallOut;
  logic        ramReq, ramWe;
  logic [15:0] ramAddr, ramWdata, ramRdata;
  logic        ramAck;
`ifdef MEM_ACCESS_MMIO_EN
  logic        ioReq, ioWe, ioSel, ioAck;
  logic [15:0] ioWdata, ioRdata;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_access dut (
    .CLK(CLK), .RST(RST),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .ALUResultIn(ALUResultIn), .storeDataIn(storeDataIn),
    .writeSpecRegIn(writeSpecRegIn), .memtoRegIn(memtoRegIn),
    .regWriteIn(regWriteIn), .registerToWriteIdIn(registerToWriteIdIn),
    .writeSpecRegOut(writeSpecRegOut), .memtoRegOut(memtoRegOut),
    .regWriteOut(regWriteOut), .registerToWriteIdOut(registerToWriteIdOut),
    .dataOut(dataOut), .ALUResultOut(ALUResultOut), .stallOut(stallOut),
    .ramReq(ramReq), .ramWe(ramWe), .ramAddr(ramAddr), .ramWdata(ramWdata),
    .ramRdata(ramRdata), .ramAck(ramAck)
`ifdef MEM_ACCESS_MMIO_EN
    , .ioReq(ioReq), .ioWe(ioWe), .ioSel(ioSel), .ioWdata(ioWdata),
    .ioRdata(ioRdata), .ioAck(ioAck)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr_inputs();
    memReadIn = 0; memWriteIn = 0; ALUResultIn = '0; storeDataIn = '0;
    writeSpecRegIn = '0; memtoRegIn = 0; regWriteIn = 0; registerToWriteIdIn = '0;
    ramRdata = '0; ramAck = 0;
`ifdef MEM_ACCESS_MMIO_EN
    ioRdata = '0; ioAck = 0;
`endif
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    clr_inputs();
    RST = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++; if (stallOut !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stallOut); end
    n_checks++; if (ramReq !== 1'b0) begin n_fail++; $display("FAIL reset_ramReq: got %0b want 0", ramReq); end
    n_checks++; if (ramWe !== 1'b0) begin n_fail++; $display("FAIL reset_ramWe: got %0b want 0", ramWe); end
    n_checks++; if (dataOut !== 16'h0) begin n_fail++; $display("FAIL reset_dataOut: got %h want 0000", dataOut); end
    n_checks++; if (ramAddr !== 16'h0) begin n_fail++; $display("FAIL reset_ramAddr: got %h want 0000", ramAddr); end
`ifdef MEM_ACCESS_MMIO_EN
    n_checks++; if (ioReq !== 1'b0) begin n_fail++; $display("FAIL reset_ioReq: got %0b want 0", ioReq); end
`endif
    @(posedge CLK); #1;
    RST = 1;
  endtask

  task automatic test_passthrough();
    clr_inputs();
    ALUResultIn = 16'h1234; regWriteIn = 1; writeSpecRegIn = 2'b10; registerToWriteIdIn = 3'd5;
    @(negedge CLK);
    n_checks++; if (ALUResultOut !== 16'h1234) begin n_fail++; $display("FAIL pass_alu: got %h want 1234", ALUResultOut); end
    n_checks++; if (regWriteOut !== 1'b1) begin n_fail++; $display("FAIL pass_regWrite: got %0b want 1", regWriteOut); end
    n_checks++; if (writeSpecRegOut !== 2'b10) begin n_fail++; $display("FAIL pass_spec: got %b want 10", writeSpecRegOut); end
    n_checks++; if (registerToWriteIdOut !== 3'd5) begin n_fail++; $display("FAIL pass_regId: got %0d want 5", registerToWriteIdOut); end
    n_checks++; if (stallOut !== 1'b0) begin n_fail++; $display("FAIL pass_stall: got %0b want 0", stallOut); end
    // same-cycle change must propagate without a clock
    ALUResultIn = 16'hABCD; memtoRegIn = 1; #1;
    n_checks++; if (ALUResultOut !== 16'hABCD) begin n_fail++; $display("FAIL pass_alu_comb: got %h want abcd", ALUResultOut); end
    n_checks++; if (memtoRegOut !== 1'b1) begin n_fail++; $display("FAIL pass_memtoReg_comb: got %0b want 1", memtoRegOut); end
    step();
  endtask

  task automatic test_load();
    clr_inputs();
    memReadIn = 1; ALUResultIn = 16'h0040; memtoRegIn = 1; regWriteIn = 1; registerToWriteIdIn = 3'd2;
    @(negedge CLK);
    n_checks++; if (stallOut !== 1'b1) begin n_fail++; $display("FAIL load_idle_stall: got %0b want 1", stallOut); end
    n_checks++; if (regWriteOut !== 1'b0) begin n_fail++; $display("FAIL load_idle_bubble: got %0b want 0", regWriteOut); end
    n_checks++; if (ramReq !== 1'b0) begin n_fail++; $display("FAIL load_idle_req: got %0b want 0", ramReq); end
    step();
    ramAck = 1; ramRdata = 16'hBEEF;
    @(negedge CLK);
    n_checks++; if (stallOut !== 1'b1) begin n_fail++; $display("FAIL load_acc_stall: got %0b want 1", stallOut); end
    n_checks++; if (ramReq !== 1'b1) begin n_fail++; $display("FAIL load_acc_req: got %0b want 1", ramReq); end
    n_checks++; if (ramAddr !== 16'h0040) begin n_fail++; $display("FAIL load_acc_addr: got %h want 0040", ramAddr); end
    n_checks++; if (ramWe !== 1'b0) begin n_fail++; $display("FAIL load_acc_we: got %0b want 0", ramWe); end
    n_checks++; if (memtoRegOut !== 1'b0) begin n_fail++; $display("FAIL load_acc_bubble: got %0b want 0", memtoRegOut); end
    step();
    ramAck = 0; ramRdata = 16'h0000;
    @(negedge CLK);
    n_checks++; if (stallOut !== 1'b0) begin n_fail++; $display("FAIL load_done_stall: got %0b want 0", stallOut); end
    n_checks++; if (dataOut !== 16'hBEEF) begin n_fail++; $display("FAIL load_done_data: got %h want beef", dataOut); end
    n_checks++; if (memtoRegOut !== 1'b1) begin n_fail++; $display("FAIL load_done_memtoReg: got %0b want 1", memtoRegOut); end
    n_checks++; if (regWriteOut !== 1'b1) begin n_fail++; $display("FAIL load_done_regWrite: got %0b want 1", regWriteOut); end
    n_checks++; if (ramReq !== 1'b0) begin n_fail++; $display("FAIL load_done_req: got %0b want 0", ramReq); end
    step();
    clr_inputs();
    @(negedge CLK);
    n_checks++; if (ramReq !== 1'b0) begin n_fail++; $display("FAIL load_after_req: got %0b want 0", ramReq); end
    n_checks++; if (stallOut !== 1'b0) begin n_fail++; $display("FAIL load_after_stall: got %0b want 0", stallOut); end
    n_checks++; if (dataOut !== 16'h0) begin n_fail++; $display("FAIL load_after_data: got %h want 0000", dataOut); end
    step();
  endtask

  task automatic test_store();
    int cyc;
    clr_inputs();
    memWriteIn = 1; ALUResultIn = 16'h0080; storeDataIn = 16'h5A5A;
    cyc = 0;
    // IDLE, three ACCESS cycles (ack on the third), DONE
    for (int c = 0; c < 5; c++) begin
      ramAck = (c == 3);
      if (c > 0) storeDataIn = 16'hFFFF;  // latched value must hold
      @(negedge CLK);
      cyc++;
      n_checks++; if (regWriteOut !== 1'b0) begin n_fail++; $display("FAIL store_c%0d_regWrite: got %0b want 0", c, regWriteOut); end
      n_checks++; if (stallOut !== (c < 4)) begin n_fail++; $display("FAIL store_c%0d_stall: got %0b want %0b", c, stallOut, (c < 4)); end
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if ({ramReq, ramWe, ramAddr, ramWdata} !== {1'b1, 1'b1, 16'h0080, 16'h5A5A}) begin
          n_fail++; $display("FAIL store_c%0d_bus: got req=%0b we=%0b addr=%h wd=%h want 1 1 0080 5a5a", c, ramReq, ramWe, ramAddr, ramWdata);
        end
      end
      step();
    end
    clr_inputs();
    @(negedge CLK);
    n_checks++; if (stallOut !== 1'b0 || ramReq !== 1'b0) begin n_fail++; $display("FAIL store_total: got stall=%0b req=%0b after %0d cycles want 0 0", stallOut, ramReq, cyc); end
    step();
  endtask

  task automatic test_reset_mid_access();
    clr_inputs();
    memReadIn = 1; ALUResultIn = 16'h0010;
    step();           // now in ACCESS (1st)
    step();           // 2nd ACCESS cycle
    RST = 0; ramAck = 1; ramRdata = 16'hDEAD;
    @(negedge CLK);
    n_checks++; if (ramReq !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_req: got %0b want 1", ramReq); end
    step();
    RST = 1; clr_inputs();
    @(negedge CLK);
    n_checks++; if (ramReq !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %0b want 0", ramReq); end
    n_checks++; if (stallOut !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %0b want 0", stallOut); end
    n_checks++; if (dataOut !== 16'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0000", dataOut); end
    n_checks++; if (ramAddr !== 16'h0) begin n_fail++; $display("FAIL rstmid_addr: got %h want 0000", ramAddr); end
    step();
    @(negedge CLK);
    n_checks++; if (dataOut !== 16'h0 || ramReq !== 1'b0) begin n_fail++; $display("FAIL rstmid_nodone: got data=%h req=%0b want 0000 0", dataOut, ramReq); end
    step();
  endtask

  task automatic test_stray_ack();
    clr_inputs();
    ramAck = 1;
    @(negedge CLK);
    n_checks++; if (stallOut !== 1'b0 || ramReq !== 1'b0) begin n_fail++; $display("FAIL stray_idle: got stall=%0b req=%0b want 0 0", stallOut, ramReq); end
    step();
    memReadIn = 1; memWriteIn = 1; ALUResultIn = 16'h0200; storeDataIn = 16'h7777;
    @(negedge CLK);
    n_checks++; if (stallOut !== 1'b1 || ramReq !== 1'b0) begin n_fail++; $display("FAIL stray_issue: got stall=%0b req=%0b want 1 0", stallOut, ramReq); end
    step();
    ramAck = 0;
    @(negedge CLK);
    n_checks++;
    if ({stallOut, ramReq, ramWe, ramWdata} !== {1'b1, 1'b1, 1'b1, 16'h7777}) begin
      n_fail++; $display("FAIL stray_write: got stall=%0b req=%0b we=%0b wd=%h want 1 1 1 7777", stallOut, ramReq, ramWe, ramWdata);
    end
    step();
    ramAck = 1;
    @(negedge CLK);
    n_checks++; if (stallOut !== 1'b1) begin n_fail++; $display("FAIL stray_ack_cycle: got %0b want 1", stallOut); end
    step();
    ramAck = 0;
    @(negedge CLK);
    n_checks++; if (stallOut !== 1'b0 || ramReq !== 1'b0) begin n_fail++; $display("FAIL stray_done: got stall=%0b req=%0b want 0 0", stallOut, ramReq); end
    step();
    clr_inputs();
  endtask

  // Model: a memory op of d extra wait cycles spans 3+d cycles; stall on all but the last,
  // RAM request on cycles 1..1+d, and a load's data appears on the last cycle.
  task automatic test_random(int n_ops);
    logic rd, wr, rw, m2r, stray;
    logic [1:0] spec;
    logic [2:0] rid;
    logic [15:0] a, wd, rv;
    int d;
    logic exp_stall, exp_req;
    for (int t = 0; t < n_ops; t++) begin
      clr_inputs();
      rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1)); m2r = 1'($urandom_range(0, 1));
      spec = 2'($urandom_range(0, 3)); rid = 3'($urandom_range(0, 7));
      a = 16'($urandom); wd = 16'($urandom); rv = 16'($urandom);
      if (a[15:8] == 8'hBF) a[15:8] = 8'h00;
      d = $urandom_range(0, 3);
      stray = 1'($urandom_range(0, 1));
      memReadIn = rd; memWriteIn = wr; ALUResultIn = a; storeDataIn = wd;
      regWriteIn = rw; memtoRegIn = m2r; writeSpecRegIn = spec; registerToWriteIdIn = rid;
      if (!(rd | wr)) begin
        ramAck = stray;
        @(negedge CLK);
        n_checks++;
        if ({stallOut, ramReq, ALUResultOut, regWriteOut, memtoRegOut, writeSpecRegOut, registerToWriteIdOut, dataOut}
            !== {1'b0, 1'b0, a, rw, m2r, spec, rid, 16'h0}) begin
          n_fail++; $display("FAIL rnd%0d_nonmem: got stall=%0b req=%0b alu=%h rw=%0b m2r=%0b sp=%b id=%0d do=%h want 0 0 %h %0b %0b %b %0d 0000",
                             t, stallOut, ramReq, ALUResultOut, regWriteOut, memtoRegOut, writeSpecRegOut, registerToWriteIdOut, dataOut,
                             a, rw, m2r, spec, rid);
        end
        step();
      end else begin
        for (int c = 0; c <= 2 + d; c++) begin
          ramAck   = (c == 1 + d) || ((c == 0 || c == 2 + d) && stray);
          ramRdata = (c == 1 + d) ? rv : 16'($urandom);
          exp_stall = (c <= 1 + d);
          exp_req   = (c >= 1) && (c <= 1 + d);
          @(negedge CLK);
          n_checks++;
          if (stallOut !== exp_stall || ramReq !== exp_req) begin
            n_fail++; $display("FAIL rnd%0d_c%0d_ctl: got stall=%0b req=%0b want %0b %0b", t, c, stallOut, ramReq, exp_stall, exp_req);
          end
          n_checks++;
          if (regWriteOut !== (exp_stall ? 1'b0 : rw)) begin
            n_fail++; $display("FAIL rnd%0d_c%0d_regWrite: got %0b want %0b", t, c, regWriteOut, (exp_stall ? 1'b0 : rw));
          end
          if (exp_req) begin
            n_checks++;
            if (ramAddr !== a || ramWe !== wr || (wr && ramWdata !== wd)) begin
              n_fail++; $display("FAIL rnd%0d_c%0d_bus: got addr=%h we=%0b wd=%h want %h %0b %h", t, c, ramAddr, ramWe, ramWdata, a, wr, wd);
            end
          end
          if (c < 2 + d) begin
            n_checks++; if (dataOut !== 16'h0) begin n_fail++; $display("FAIL rnd%0d_c%0d_data0: got %h want 0000", t, c, dataOut); end
          end else if (!wr) begin
            n_checks++; if (dataOut !== rv) begin n_fail++; $display("FAIL rnd%0d_load_data: got %h want %h", t, dataOut, rv); end
          end
          step();
        end
      end
    end
    clr_inputs();
  endtask

`ifdef MEM_ACCESS_MMIO_EN
  task automatic test_mmio();
    clr_inputs();
    memReadIn = 1; ALUResultIn = 16'hBF01;
    step();
    ioAck = 1; ioRdata = 16'h0003; ramAck = 1; ramRdata = 16'hFFFF;
    @(negedge CLK);
    n_checks++;
    if ({ioReq, ioSel, ioWe, ramReq, stallOut} !== 5'b11001) begin
      n_fail++; $display("FAIL mmio_access: got ioReq=%0b ioSel=%0b ioWe=%0b ramReq=%0b stall=%0b want 1 1 0 0 1", ioReq, ioSel, ioWe, ramReq, stallOut);
    end
    step();
    ioAck = 0; ramAck = 0;
    @(negedge CLK);
    n_checks++; if (dataOut !== 16'h0003) begin n_fail++; $display("FAIL mmio_done_data: got %h want 0003", dataOut); end
    step();
    clr_inputs();
    memReadIn = 1; ALUResultIn = 16'h0040;
    step();
    ioAck = 1; ramAck = 1; ramRdata = 16'h4242;
    @(negedge CLK);
    n_checks++; if (ioReq !== 1'b0 || ramReq !== 1'b1) begin n_fail++; $display("FAIL mmio_ram_route: got ioReq=%0b ramReq=%0b want 0 1", ioReq, ramReq); end
    step();
    clr_inputs();
    @(negedge CLK);
    n_checks++; if (dataOut !== 16'h4242) begin n_fail++; $display("FAIL mmio_ram_data: got %h want 4242", dataOut); end
    step();
  endtask
`endif

  initial begin
    RST = 0;
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_reset_mid_access();
    test_stray_ack();
`ifdef MEM_ACCESS_MMIO_EN
    test_mmio();
`endif
    test_random(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data and address width.
REQ-002 Parameter MMIO_BASE, default 16'hBF00, SHALL set the serial data address; MMIO_BASE+1 is the status address.
REQ-003 Ports SHALL be (name  direction  width  meaning):
 CLK  in  1  pipeline clock, rising edge.
 RST  in  1  reset, synchronous, active-low.
 memReadIn  in  1  EX_MEM load request.
 memWriteIn  in  1  EX_MEM store request.
 ALUResultIn  in  16  effective address, or ALU result for non-memory ops.
 storeDataIn  in  16  store data.
 writeSpecRegIn / memtoRegIn / regWriteIn / registerToWriteIdIn  in  2/1/1/3  writeback controls from EX_MEM.
 writeSpecRegOut / memtoRegOut / regWriteOut / registerToWriteIdOut  out  2/1/1/3  writeback controls to MEM_WB.
 dataOut  out  16  load data to MEM_WB.
 ALUResultOut  out  16  ALUResultIn passed through.
 stallOut  out  1  hold PC/IF_ID/ID_EX/EX_MEM when high.
 ramReq / ramWe  out  1/1  RAM request, write enable.
 ramAddr / ramWdata  out  16/16  RAM address, write data.
 ramRdata  in  16  RAM read data, valid when ramAck is high.
 ramAck  in  1  single-cycle completion.
 ioReq / ioWe / ioSel / ioWdata / ioRdata / ioAck  out/out/out/out/in/in  1/1/1/16/16/1  MMIO port; present only under REQ-019.

Function
REQ-004 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-005 In IDLE with (memReadIn|memWriteIn)=1, the block SHALL latch address, store data and direction, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-006 In ACCESS, ramReq SHALL be high, with ramAddr, ramWdata and ramWe driven from latched values and held stable until ramAck.
REQ-007 In ACCESS with ramAck=1, a load SHALL capture ramRdata into the data register, and the FSM SHALL go to DONE; ack in the first ACCESS cycle is legal.
REQ-008 DONE SHALL last exactly one cycle, then go to IDLE unconditionally; a memory op in DONE SHALL NOT start a new access.
REQ-009 stallOut SHALL be (IDLE & (memReadIn|memWriteIn)) | ACCESS, and SHALL be low in DONE.
REQ-010 While stallOut=1, regWriteOut, memtoRegOut and writeSpecRegOut SHALL be 0 (bubble to MEM_WB).
REQ-011 Outside stall, all writeback controls and ALUResultOut SHALL pass through combinationally.
REQ-012 dataOut SHALL be the data register in DONE, and 0 otherwise.
REQ-013 Minimum memory-op latency SHALL be 3 cycles (IDLE, ACCESS, DONE), plus 1 cycle per extra ACCESS cycle before ack.
REQ-014 Non-memory ops SHALL take 1 cycle with no stall.
REQ-015 If memReadIn and memWriteIn are both 1, the op SHALL be treated as a write.
REQ-016 ramAck outside ACCESS SHALL be ignored.

Reset
REQ-017 On an RST=0 edge, the block SHALL go to IDLE, clear the data register and latches, and drive ramReq=0, ramWe=0, ioReq=0 and stallOut=0 from the next cycle.
REQ-018 Reset during ACCESS SHALL abandon the access, with no DONE cycle and no capture.

Configuration
REQ-019 With MEM_ACCESS_MMIO_EN defined, addresses MMIO_BASE and MMIO_BASE+1 SHALL use the io* handshake in place of ram*, with ioSel=address bit 0 and identical FSM timing; ramReq SHALL stay 0 for those accesses.
REQ-020 Without MEM_ACCESS_MMIO_EN, io* ports SHALL be absent, and all addresses SHALL go to RAM.

Structure
REQ-021 Package mem_access_pkg SHALL hold the state enum, MMIO_BASE default and DATA_W.
REQ-022 The block SHALL be a single module with no sub-module; MMIO decode SHALL be inline.

Verification
REQ-023 Non-memory op, ALUResultIn=16'h1234, regWriteIn=1 -> same-cycle pass-through, stallOut=0.
REQ-024 Load at 16'h0040, ramAck in first ACCESS cycle with ramRdata=16'hBEEF -> stallOut high 2 cycles; DONE gives dataOut=16'hBEEF and memtoRegOut=1.
REQ-025 Store 16'h5A5A to 16'h0080, ack after 3 ACCESS cycles -> ramWe=1, ramAddr and ramWdata stable, regWriteOut=0 throughout, 5-cycle total.
REQ-026 RST=0 in 2nd ACCESS cycle -> ramReq=0 and IDLE next cycle, no DONE, dataOut=0.
REQ-027 Stray ramAck in IDLE, then memReadIn=memWriteIn=1 -> ack ignored, write issued.
REQ-028 With MEM_ACCESS_MMIO_EN, load at 16'hBF01, ioRdata=16'h0003 -> ioReq/ioSel=1, ramReq=0, dataOut=16'h0003 in DONE.
